// File: rtl/ctrl_pkg.sv
// Shared constants for the main control FSM: state encoding, per-state control
// vectors and op codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        MULWAIT = 4'd10,
        MULWB   = 4'd11,
        TRAP    = 4'd12
    } state_t;

    // {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    localparam logic [12:0] CV_FETCH   = 13'h100C;
    localparam logic [12:0] CV_DECODE  = 13'h004C;
    localparam logic [12:0] CV_MEMADR  = 13'h0002;
    localparam logic [12:0] CV_MEMRD   = 13'h0080;
    localparam logic [12:0] CV_MEMWB   = 13'h0220;
    localparam logic [12:0] CV_MEMWR   = 13'h0480;
    localparam logic [12:0] CV_EXECR   = 13'h0001;
    localparam logic [12:0] CV_EXECI   = 13'h0003;
    localparam logic [12:0] CV_ALUWB   = 13'h0200;
    localparam logic [12:0] CV_BRANCH  = 13'h0852;
    localparam logic [12:0] CV_MULWAIT = 13'h0001;
    localparam logic [12:0] CV_MULWB   = 13'h0200;
    localparam logic [12:0] CV_TRAP    = 13'h0000;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    function automatic logic [12:0] cv_of(input state_t s);
        case (s)
            FETCH:   cv_of = CV_FETCH;
            DECODE:  cv_of = CV_DECODE;
            MEMADR:  cv_of = CV_MEMADR;
            MEMRD:   cv_of = CV_MEMRD;
            MEMWB:   cv_of = CV_MEMWB;
            MEMWR:   cv_of = CV_MEMWR;
            EXECR:   cv_of = CV_EXECR;
            EXECI:   cv_of = CV_EXECI;
            ALUWB:   cv_of = CV_ALUWB;
            BRANCH:  cv_of = CV_BRANCH;
            MULWAIT: cv_of = CV_MULWAIT;
            MULWB:   cv_of = CV_MULWB;
            default: cv_of = CV_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Instruction/memory-status inputs and datapath control outputs of the main
// control FSM; master is the FSM, slave is the datapath side.
interface main_ctrl_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       MulStart;
    logic [3:0] StateDbg;
    logic       IllegalInstr;

    modport master (
        input  Op, Funct, IsMul, MemReady,
        output IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, NextPC, RegW,
               MemW, Branch, ALUOp, MulStart, StateDbg, IllegalInstr
    );

    modport slave (
        output Op, Funct, IsMul, MemReady,
        input  IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, NextPC, RegW,
               MemW, Branch, ALUOp, MulStart, StateDbg, IllegalInstr
    );
endinterface

// File: rtl/mul_wait_cnt.sv
// Multiply latency counter: loads a start value, counts down to zero and holds.
module mul_wait_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/main_ctrl_fsm.sv
// Main control FSM of the multi-cycle core with memory stall and multi-cycle multiply.
// Build option MAIN_CTRL_FSM_TRAP_EN: Op=11 traps to TRAP instead of executing as NOP.
module main_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    main_ctrl_fsm_if.master bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_t      state;
    logic        dp_reg;
    logic        mul_go;
    logic        mul_done;
    logic [12:0] cv;
    logic        unused_funct;

    assign dp_reg       = (bus.Op == OP_DP) && !bus.Funct[5];
    assign mul_go       = (state == DECODE) && dp_reg && bus.IsMul;
    assign unused_funct = ^bus.Funct[4:1];

    mul_wait_cnt #(.CNT_W(CNT_W)) u_mul_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (mul_go),
        .dec      (state == MULWAIT),
        .load_val (MUL_LOAD),
        .zero     (mul_done)
    );

    // State register and next-state decode; MemReady only matters in the memory-access states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (bus.MemReady) state <= DECODE;
                DECODE: begin
                    if (bus.Op == OP_DP)
                        state <= bus.Funct[5] ? EXECI : (bus.IsMul ? MULWAIT : EXECR);
                    else if (bus.Op == OP_MEM)
                        state <= MEMADR;
                    else if (bus.Op == OP_BR)
                        state <= BRANCH;
                    else
`ifdef MAIN_CTRL_FSM_TRAP_EN
                        state <= TRAP;
`else
                        state <= FETCH;
`endif
                end
                MEMADR:  state <= bus.Funct[0] ? MEMRD : MEMWR;
                MEMRD:   if (bus.MemReady) state <= MEMWB;
                MEMWR:   if (bus.MemReady) state <= FETCH;
                EXECR,
                EXECI:   state <= ALUWB;
                MULWAIT: if (mul_done) state <= MULWB;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // The fetch vector's NextPC and IRWrite only fire once memory returns the instruction
    always_comb begin
        cv = cv_of(state);
        if (state == FETCH) begin
            cv[12] = bus.MemReady;
            cv[8]  = bus.MemReady;
        end
    end

    assign {bus.NextPC, bus.Branch, bus.MemW, bus.RegW, bus.IRWrite, bus.AdrSrc,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} = cv;

    assign bus.MulStart = mul_go;
    assign bus.StateDbg = state;

`ifdef MAIN_CTRL_FSM_TRAP_EN
    assign bus.IllegalInstr = (state == TRAP);
`else
    assign bus.IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench for main_ctrl_fsm: two instances (multiply latency 3 and 1)
// driven by directed per-cycle vectors with hand-computed control outputs.
module tb_main_ctrl_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    main_ctrl_fsm_if ifa ();
    main_ctrl_fsm_if ifb ();

    main_ctrl_fsm #(.MUL_LATENCY(3), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    main_ctrl_fsm #(.MUL_LATENCY(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    localparam logic [12:0] V_F0    = 13'h000C;
    localparam logic [12:0] V_F1    = 13'h110C;
    localparam logic [12:0] V_DEC   = 13'h004C;
    localparam logic [12:0] V_MADR  = 13'h0002;
    localparam logic [12:0] V_MRD   = 13'h0080;
    localparam logic [12:0] V_MWB   = 13'h0220;
    localparam logic [12:0] V_MWR   = 13'h0480;
    localparam logic [12:0] V_EXR   = 13'h0001;
    localparam logic [12:0] V_EXI   = 13'h0003;
    localparam logic [12:0] V_AWB   = 13'h0200;
    localparam logic [12:0] V_BR    = 13'h0852;
    localparam logic [12:0] V_MUL   = 13'h0001;
    localparam logic [12:0] V_MULWB = 13'h0200;
    localparam logic [12:0] V_TRAP  = 13'h0000;

    typedef struct {
        bit         which;
        logic [3:0] st;
        logic [12:0] cv;
        logic       ms;
        logic       il;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the selected DUT, queue what it must show, advance a clock
    task automatic applyStimulus(input bit which, input logic [1:0] op, input logic [5:0] funct,
                                 input logic ismul, input logic mr, input logic [3:0] st,
                                 input logic [12:0] cv, input logic ms = 1'b0, input logic il = 1'b0);
        exp_t r;
        if (!which) begin
            ifa.Op = op; ifa.Funct = funct; ifa.IsMul = ismul; ifa.MemReady = mr;
            ifb.MemReady = 1'b0;
        end else begin
            ifb.Op = op; ifb.Funct = funct; ifb.IsMul = ismul; ifb.MemReady = mr;
            ifa.MemReady = 1'b0;
        end
        r.which = which; r.st = st; r.cv = cv; r.ms = ms; r.il = il;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            if (!e.which) begin
                checkOutput("A.state", {12'd0, ifa.StateDbg}, {12'd0, e.st});
                checkOutput("A.ctrl", {3'd0, ifa.NextPC, ifa.Branch, ifa.MemW, ifa.RegW, ifa.IRWrite,
                            ifa.AdrSrc, ifa.ResultSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp}, {3'd0, e.cv});
                checkOutput("A.mulstart", {15'd0, ifa.MulStart}, {15'd0, e.ms});
                checkOutput("A.illegal", {15'd0, ifa.IllegalInstr}, {15'd0, e.il});
            end else begin
                checkOutput("B.state", {12'd0, ifb.StateDbg}, {12'd0, e.st});
                checkOutput("B.ctrl", {3'd0, ifb.NextPC, ifb.Branch, ifb.MemW, ifb.RegW, ifb.IRWrite,
                            ifb.AdrSrc, ifb.ResultSrc, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp}, {3'd0, e.cv});
                checkOutput("B.mulstart", {15'd0, ifb.MulStart}, {15'd0, e.ms});
                checkOutput("B.illegal", {15'd0, ifb.IllegalInstr}, {15'd0, e.il});
            end
        end
    end

    initial begin
        ifa.Op = 2'b00; ifa.Funct = 6'd0; ifa.IsMul = 1'b0; ifa.MemReady = 1'b0;
        ifb.Op = 2'b00; ifb.Funct = 6'd0; ifb.IsMul = 1'b0; ifb.MemReady = 1'b0;
        @(posedge clk);
        #1;

        // reset held: FETCH with fetch strobes gated off
        applyStimulus(0, 2'b00, 6'd0, 0, 0, 4'd0, V_F0);
        reset = 1'b0;

        // fetch stall 3 cycles, then ready; LDR with 2 read-stall cycles
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b01, 6'h01, 0, 0, 4'd0, V_F0);
        applyStimulus(0, 2'b01, 6'h01, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b01, 6'h01, 0, 1, 4'd1, V_DEC);
        applyStimulus(0, 2'b01, 6'h01, 0, 1, 4'd2, V_MADR);
        applyStimulus(0, 2'b01, 6'h01, 0, 0, 4'd3, V_MRD);
        applyStimulus(0, 2'b01, 6'h01, 0, 0, 4'd3, V_MRD);
        applyStimulus(0, 2'b01, 6'h01, 0, 1, 4'd3, V_MRD);
        applyStimulus(0, 2'b01, 6'h01, 0, 0, 4'd4, V_MWB);

        // STR with one write-stall cycle
        applyStimulus(0, 2'b01, 6'h00, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b01, 6'h00, 0, 0, 4'd1, V_DEC);
        applyStimulus(0, 2'b01, 6'h00, 0, 0, 4'd2, V_MADR);
        applyStimulus(0, 2'b01, 6'h00, 0, 0, 4'd5, V_MWR);
        applyStimulus(0, 2'b01, 6'h00, 0, 1, 4'd5, V_MWR);

        // MUL, latency 3
        applyStimulus(0, 2'b00, 6'h00, 1, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd1, V_DEC, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 6'h00, 1, 1, 4'd10, V_MUL);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd11, V_MULWB);

        // branch
        applyStimulus(0, 2'b10, 6'h00, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b10, 6'h00, 0, 0, 4'd1, V_DEC);
        applyStimulus(0, 2'b10, 6'h00, 0, 0, 4'd9, V_BR);

        // immediate DP with IsMul set: must not start the multiplier
        applyStimulus(0, 2'b00, 6'h20, 1, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b00, 6'h20, 1, 0, 4'd1, V_DEC);
        applyStimulus(0, 2'b00, 6'h20, 1, 0, 4'd7, V_EXI);
        applyStimulus(0, 2'b00, 6'h20, 1, 0, 4'd8, V_AWB);

        // register DP
        applyStimulus(0, 2'b00, 6'h00, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b00, 6'h00, 0, 0, 4'd1, V_DEC);
        applyStimulus(0, 2'b00, 6'h00, 0, 0, 4'd6, V_EXR);
        applyStimulus(0, 2'b00, 6'h00, 0, 0, 4'd8, V_AWB);

        // asynchronous reset in the middle of MULWAIT
        applyStimulus(0, 2'b00, 6'h00, 1, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd1, V_DEC, 1'b1);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd10, V_MUL);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mulwait_state", {12'd0, ifa.StateDbg}, 16'd0);
        checkOutput("rst_mulwait_mulstart", {15'd0, ifa.MulStart}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // full multiply again after the interrupted one
        applyStimulus(0, 2'b00, 6'h00, 1, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd1, V_DEC, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd10, V_MUL);
        applyStimulus(0, 2'b00, 6'h00, 1, 0, 4'd11, V_MULWB);

        // MUL on the latency-1 instance
        applyStimulus(1, 2'b00, 6'h00, 1, 1, 4'd0, V_F1);
        applyStimulus(1, 2'b00, 6'h00, 1, 0, 4'd1, V_DEC, 1'b1);
        applyStimulus(1, 2'b00, 6'h00, 1, 0, 4'd10, V_MUL);
        applyStimulus(1, 2'b00, 6'h00, 1, 0, 4'd11, V_MULWB);
        applyStimulus(1, 2'b00, 6'h00, 0, 0, 4'd0, V_F0);

        // undefined op
        applyStimulus(0, 2'b11, 6'h00, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b11, 6'h00, 0, 0, 4'd1, V_DEC);
`ifdef MAIN_CTRL_FSM_TRAP_EN
        for (int i = 0; i < 10; i++) applyStimulus(0, 2'b11, 6'h00, 0, 1, 4'd12, V_TRAP, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_trap_state", {12'd0, ifa.StateDbg}, 16'd0);
        checkOutput("rst_trap_illegal", {15'd0, ifa.IllegalInstr}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`else
        applyStimulus(0, 2'b11, 6'h00, 0, 0, 4'd0, V_F0);
        applyStimulus(0, 2'b11, 6'h00, 0, 1, 4'd0, V_F1);
        applyStimulus(0, 2'b11, 6'h00, 0, 0, 4'd1, V_DEC);
`endif

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 16'(q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
